// File: rtl/udma_hyper_pkg.sv
// Shared types and helpers for the uDMA hyperbus channel scheduler.
package udma_hyper_pkg;

  localparam int unsigned HYPER_ADDR_W  = 32;
  localparam int unsigned HYPER_TRANS_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [HYPER_ADDR_W-1:0]  addr;
    logic [HYPER_TRANS_W-1:0] size;
    logic                     rwn;
  } hyper_req_t;

  // Page size in bytes for a boundary code; 0 means no boundary.
  function automatic logic [31:0] page_size(input logic [2:0] code);
    case (code)
      3'd1:    return 32'd128;
      3'd2:    return 32'd256;
      3'd3:    return 32'd512;
      3'd4:    return 32'd1024;
      3'd5:    return 32'd2048;
      3'd6:    return 32'd4096;
      3'd7:    return 32'd8192;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/udma_hyper_rr_arb.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module udma_hyper_rr_arb
  import udma_hyper_pkg::*;
#(
  parameter int NB_CH = 2,
  parameter int IDW   = 1
) (
  input  logic [NB_CH-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [IDW-1:0]   o_idx,
  output logic             o_valid
);

  logic [IDW-1:0] w_cand;

  // Scan from farthest to nearest so the candidate closest to the pointer wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = NB_CH - 1; k >= 0; k--) begin
      w_cand  = IDW'((int'(i_ptr) + k) % NB_CH);
      o_idx   = i_req[w_cand] ? w_cand : o_idx;
      o_valid = o_valid | i_req[w_cand];
    end
  end

endmodule

// File: rtl/udma_hyper_ch_sched.sv
// Schedules one uDMA hyperbus channel transaction at a time onto the PHY,
// splitting it into bursts that never cross the configured page boundary.
module udma_hyper_ch_sched
  import udma_hyper_pkg::*;
#(
  parameter int NB_CH      = 2,
  parameter int TRANS_SIZE = 16,
  parameter int ADDR_W     = 32,
  localparam int IDW       = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [2:0]                   cfg_page_bound_i,
  input  logic [NB_CH-1:0]             req_valid_i,
  output logic [NB_CH-1:0]             req_ready_o,
  input  logic [NB_CH-1:0]             req_rwn_i,
  input  logic [NB_CH*ADDR_W-1:0]      req_addr_i,
  input  logic [NB_CH*TRANS_SIZE-1:0]  req_size_i,
  output logic                         phy_valid_o,
  input  logic                         phy_ready_i,
  output logic [ADDR_W-1:0]            phy_addr_o,
  output logic [TRANS_SIZE-1:0]        phy_len_o,
  output logic                         phy_rwn_o,
  output logic [IDW-1:0]               phy_id_o,
  output logic                         phy_last_o,
  input  logic                         phy_done_i,
  output logic [NB_CH-1:0]             busy_vec_o
);

  sched_state_e          r_state;
  logic [IDW-1:0]        r_ptr;
  logic [ADDR_W-1:0]     r_addr;
  logic [TRANS_SIZE-1:0] r_rem;
  logic                  r_rwn;
  logic [IDW-1:0]        r_id;
  logic [2:0]            r_page;
  logic [NB_CH-1:0]      r_busy;
  logic                  r_phy_valid;
  logic [TRANS_SIZE-1:0] r_len;
  logic                  r_last;

  logic [IDW-1:0]        w_gnt_idx;
  logic                  w_gnt_valid;
  logic [IDW-1:0]        w_ptr_nxt;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [TRANS_SIZE-1:0] w_sel_size;
  logic                  w_sel_rwn;
  logic [TRANS_SIZE-1:0] w_len_first;
  logic [ADDR_W-1:0]     w_nxt_addr;
  logic [TRANS_SIZE-1:0] w_nxt_rem;
  logic [TRANS_SIZE-1:0] w_len_next;

  // Bytes left before the page edge, held one bit wider than a length so 2^TRANS_SIZE fits.
  function automatic logic [TRANS_SIZE-1:0] calc_len(input logic [13:0]           a_lo,
                                                     input logic [TRANS_SIZE-1:0] rem,
                                                     input logic [2:0]            code);
    logic [31:0]         p_size;
    logic [31:0]         p_off;
    logic [TRANS_SIZE:0] p_room;
    p_size = page_size(code);
    p_off  = 32'(a_lo) & (p_size - 32'd1);
    p_room = (TRANS_SIZE+1)'(p_size - p_off);
    if ((code == 3'd0) || ({1'b0, rem} <= p_room)) begin
      return rem;
    end else begin
      return p_room[TRANS_SIZE-1:0];
    end
  endfunction

  udma_hyper_rr_arb #(
    .NB_CH (NB_CH),
    .IDW   (IDW)
  ) u_arb (
    .i_req   (req_valid_i),
    .i_ptr   (r_ptr),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  // Mux the granted channel's request fields out of the packed buses.
  always_comb begin
    w_sel_addr = '0;
    w_sel_size = '0;
    w_sel_rwn  = 1'b0;
    for (int c = 0; c < NB_CH; c++) begin
      w_sel_addr = w_sel_addr | (req_addr_i[c*ADDR_W +: ADDR_W] & {ADDR_W{w_gnt_idx == IDW'(c)}});
      w_sel_size = w_sel_size | (req_size_i[c*TRANS_SIZE +: TRANS_SIZE] & {TRANS_SIZE{w_gnt_idx == IDW'(c)}});
      w_sel_rwn  = w_sel_rwn | (req_rwn_i[c] & (w_gnt_idx == IDW'(c)));
    end
  end

  assign w_ptr_nxt   = (w_gnt_idx == IDW'(NB_CH - 1)) ? '0 : w_gnt_idx + IDW'(1);
  assign w_len_first = calc_len(w_sel_addr[13:0], w_sel_size, cfg_page_bound_i);
  assign w_nxt_addr  = r_addr + ADDR_W'(r_len);
  assign w_nxt_rem   = r_rem - r_len;
  assign w_len_next  = calc_len(w_nxt_addr[13:0], w_nxt_rem, r_page);

  assign req_ready_o = ((r_state == GRANT) && w_gnt_valid) ? (NB_CH'(1) << w_gnt_idx) : '0;
  assign phy_valid_o = r_phy_valid;
  assign phy_addr_o  = r_addr;
  assign phy_len_o   = r_len;
  assign phy_rwn_o   = r_rwn;
  assign phy_id_o    = r_id;
  assign phy_last_o  = r_last;
  assign busy_vec_o  = r_busy;

  // Scheduler FSM; burst length is precomputed so the command is stable in ISSUE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_addr      <= '0;
      r_rem       <= '0;
      r_rwn       <= 1'b0;
      r_id        <= '0;
      r_page      <= 3'd0;
      r_busy      <= '0;
      r_phy_valid <= 1'b0;
      r_len       <= '0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_busy  <= '0;
          r_state <= (|req_valid_i) ? GRANT : IDLE;
        end
        GRANT: begin
          if (w_gnt_valid) begin
            r_addr <= w_sel_addr;
            r_rem  <= w_sel_size;
            r_rwn  <= w_sel_rwn;
            r_id   <= w_gnt_idx;
            r_page <= cfg_page_bound_i;
            r_ptr  <= w_ptr_nxt;
            r_busy <= NB_CH'(1) << w_gnt_idx;
            r_len  <= w_len_first;
            r_last <= (w_len_first == w_sel_size);
            if (w_sel_size == '0) begin
              r_state <= IDLE;
            end else begin
              r_phy_valid <= 1'b1;
              r_state     <= ISSUE;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          if (phy_ready_i) begin
            r_phy_valid <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (phy_done_i) begin
            r_addr <= w_nxt_addr;
            r_rem  <= w_nxt_rem;
            if (r_last) begin
              r_busy  <= '0;
              r_state <= IDLE;
            end else begin
              r_len       <= w_len_next;
              r_last      <= (w_len_next == w_nxt_rem);
              r_phy_valid <= 1'b1;
              r_state     <= ISSUE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_phy_valid <= 1'b0;
          r_busy      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udma_hyper_ch_sched.sv
// Randomised self-checking bench for udma_hyper_ch_sched with a burst-list reference model.
module tb_udma_hyper_ch_sched;

  localparam int NB_CH      = 2;
  localparam int TRANS_SIZE = 16;
  localparam int ADDR_W     = 32;
  localparam int IDW        = 1;

  logic                        clk = 1'b0;
  logic                        rst_ni;
  logic [2:0]                  cfg;
  logic [NB_CH-1:0]            req_valid;
  logic [NB_CH-1:0]            req_ready;
  logic [NB_CH-1:0]            req_rwn;
  logic [NB_CH*ADDR_W-1:0]     req_addr;
  logic [NB_CH*TRANS_SIZE-1:0] req_size;
  logic                        phy_valid;
  logic                        phy_ready;
  logic [ADDR_W-1:0]           phy_addr;
  logic [TRANS_SIZE-1:0]       phy_len;
  logic                        phy_rwn;
  logic [IDW-1:0]              phy_id;
  logic                        phy_last;
  logic                        phy_done;
  logic [NB_CH-1:0]            busy;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  udma_hyper_ch_sched #(
    .NB_CH      (NB_CH),
    .TRANS_SIZE (TRANS_SIZE),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .cfg_page_bound_i (cfg),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_rwn_i        (req_rwn),
    .req_addr_i       (req_addr),
    .req_size_i       (req_size),
    .phy_valid_o      (phy_valid),
    .phy_ready_i      (phy_ready),
    .phy_addr_o       (phy_addr),
    .phy_len_o        (phy_len),
    .phy_rwn_o        (phy_rwn),
    .phy_id_o         (phy_id),
    .phy_last_o       (phy_last),
    .phy_done_i       (phy_done),
    .busy_vec_o       (busy)
  );

  function automatic int model_pick(input logic [NB_CH-1:0] v);
    for (int k = 0; k < NB_CH; k++) begin
      if (v[(m_ptr + k) % NB_CH]) return (m_ptr + k) % NB_CH;
    end
    return -1;
  endfunction

  task automatic set_req(input int ch, input logic [31:0] addr, input int size, input bit rwn);
    req_addr[ch*ADDR_W +: ADDR_W]         = addr;
    req_size[ch*TRANS_SIZE +: TRANS_SIZE] = TRANS_SIZE'(size);
    req_rwn[ch]                           = rwn;
    req_valid[ch]                         = 1'b1;
  endtask

  // Waits for a grant, checks it against the model, then plays the PHY side of every burst.
  task automatic serve(input bit keep, input int dmin, input int dmax, input bit chk_lat,
                       output int gch, output int nb);
    int               exp_g, cyc, d, w, rem, len, psz;
    longint           la;
    logic [31:0]      a;
    bit               rwn, lst;
    logic [2:0]       code;
    logic [NB_CH-1:0] exp_oh;
    logic [31:0]      q_addr[$];
    int               q_len[$];
    nb    = 0;
    gch   = -1;
    exp_g = model_pick(req_valid);
    if (exp_g < 0) begin
      checks++; errors++;
      $display("FAIL serve_setup: no requester active, got none required one");
      return;
    end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (req_ready == '0 && cyc < 40);
    checks++;
    if (req_ready == '0) begin
      errors++;
      $display("FAIL grant_timeout: got no req_ready_o after %0d cycles, expected channel %0d", cyc, exp_g);
      return;
    end
    for (int c = 0; c < NB_CH; c++) if (req_ready[c]) gch = c;
    exp_oh = '0;
    exp_oh[exp_g] = 1'b1;
    if (req_ready !== exp_oh) begin
      errors++;
      $display("FAIL grant: got req_ready_o=%b expected %b", req_ready, exp_oh);
    end
    if (chk_lat) begin
      checks++;
      if (cyc !== 1) begin
        errors++;
        $display("FAIL grant_latency: got %0d cycles expected 1", cyc);
      end
    end
    a    = req_addr[exp_g*ADDR_W +: ADDR_W];
    rem  = int'(req_size[exp_g*TRANS_SIZE +: TRANS_SIZE]);
    rwn  = req_rwn[exp_g];
    code = cfg;
    psz  = (code == 3'd0) ? 0 : (1 << (int'(code) + 6));
    while (rem > 0) begin
      la  = longint'(a);
      len = (psz == 0) ? rem : ((rem < psz - int'(la % psz)) ? rem : psz - int'(la % psz));
      q_addr.push_back(a);
      q_len.push_back(len);
      a   = a + 32'(len);
      rem = rem - len;
    end
    m_ptr = (exp_g + 1) % NB_CH;
    @(negedge clk);
    if (!keep) req_valid[exp_g] = 1'b0;
    cfg = 3'($urandom_range(0, 7));
    checks++;
    if (busy !== exp_oh) begin
      errors++;
      $display("FAIL busy_set: got %b expected %b", busy, exp_oh);
    end
    if (q_len.size() == 0) begin
      checks++;
      if (phy_valid !== 1'b0) begin
        errors++;
        $display("FAIL size0_no_cmd: got phy_valid=%b expected 0", phy_valid);
      end
      @(negedge clk);
      checks++;
      if (busy !== '0 || phy_valid !== 1'b0) begin
        errors++;
        $display("FAIL size0_clear: got busy=%b phy_valid=%b expected 00/0", busy, phy_valid);
      end
      return;
    end
    for (int i = 0; i < q_len.size(); i++) begin
      lst = (i == q_len.size() - 1);
      checks++;
      if (phy_valid !== 1'b1) begin
        errors++;
        $display("FAIL issue: burst %0d got phy_valid=%b expected 1", i, phy_valid);
        return;
      end
      checks++;
      if ({phy_addr, phy_len, phy_rwn, phy_id, phy_last} !==
          {q_addr[i], TRANS_SIZE'(q_len[i]), rwn, IDW'(exp_g), lst}) begin
        errors++;
        $display("FAIL burst_fields: burst %0d got addr=%h len=%0d rwn=%b id=%0d last=%b expected addr=%h len=%0d rwn=%b id=%0d last=%b",
                 i, phy_addr, phy_len, phy_rwn, phy_id, phy_last, q_addr[i], q_len[i], rwn, exp_g, lst);
      end
      d = $urandom_range(dmin, dmax);
      for (int j = 0; j < d; j++) begin
        phy_done = (j == 1);
        @(negedge clk);
        phy_done = 1'b0;
        checks++;
        if (phy_valid !== 1'b1 || {phy_addr, phy_len, phy_last} !== {q_addr[i], TRANS_SIZE'(q_len[i]), lst}) begin
          errors++;
          $display("FAIL stall_stable: burst %0d got valid=%b addr=%h len=%0d expected 1 %h %0d",
                   i, phy_valid, phy_addr, phy_len, q_addr[i], q_len[i]);
        end
      end
      phy_ready = 1'b1;
      @(negedge clk);
      phy_ready = 1'b0;
      nb++;
      checks++;
      if (phy_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_state: got phy_valid=%b expected 0 after handshake", phy_valid);
      end
      w = $urandom_range(0, 3);
      repeat (w) @(negedge clk);
      phy_done = 1'b1;
      @(negedge clk);
      phy_done = 1'b0;
      if (lst) begin
        checks++;
        if (busy !== '0 || phy_valid !== 1'b0) begin
          errors++;
          $display("FAIL txn_end: got busy=%b phy_valid=%b expected 00/0", busy, phy_valid);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    cfg       = 3'd0;
    req_valid = '0;
    req_rwn   = '0;
    req_addr  = '0;
    req_size  = '0;
    phy_ready = 1'b0;
    phy_done  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, phy_valid, phy_addr, phy_len, phy_rwn, phy_id, phy_last, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b addr=%h len=%0d busy=%b expected all 0",
               req_ready, phy_valid, phy_addr, phy_len, busy);
    end
    rst_ni = 1'b1;
    m_ptr  = 0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int g, nb;
    cfg = 3'd0;
    set_req(0, 32'h0000_0100, 64, 1'b1);
    serve(1'b0, 0, 0, 1'b1, g, nb);
    checks++;
    if (nb !== 1) begin
      errors++;
      $display("FAIL single_bursts: got %0d bursts expected 1", nb);
    end
  endtask

  task automatic test_page_split();
    int g, nb;
    cfg = 3'd1;
    set_req(0, 32'h0000_0070, 300, 1'b0);
    serve(1'b0, 0, 3, 1'b1, g, nb);
    checks++;
    if (nb !== 4) begin
      errors++;
      $display("FAIL split_bursts: got %0d bursts expected 4", nb);
    end
  endtask

  task automatic test_size0();
    int g, nb;
    cfg = 3'd0;
    set_req(1, 32'h0000_0040, 0, 1'b1);
    serve(1'b0, 0, 0, 1'b1, g, nb);
    checks++;
    if (g !== 1) begin
      errors++;
      $display("FAIL size0_grant: got channel %0d expected 1", g);
    end
  endtask

  task automatic test_drop();
    set_req(1, 32'h0000_0500, 16, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL drop_offer: got req_ready_o=%b expected 10", req_ready);
    end
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== '0 || phy_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_not_granted: got busy=%b phy_valid=%b expected 00/0", busy, phy_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int g, nb;
    int exp_seq[4] = '{0, 1, 0, 1};
    cfg = 3'd0;
    set_req(0, 32'h0000_0000, 8, 1'b1);
    set_req(1, 32'h0000_0040, 8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, 0, 2, 1'b1, g, nb);
      checks++;
      if (g !== exp_seq[i]) begin
        errors++;
        $display("FAIL rr_order: grant %0d got channel %0d expected %0d", i, g, exp_seq[i]);
      end
    end
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_pressure();
    int g, nb;
    cfg = 3'd2;
    set_req(1, 32'h0000_00F0, 40, 1'b0);
    serve(1'b0, 5, 5, 1'b1, g, nb);
    checks++;
    if (nb !== 2) begin
      errors++;
      $display("FAIL bp_bursts: got %0d bursts expected 2", nb);
    end
  endtask

  task automatic test_random();
    int g, nb, ch, sz;
    logic [31:0] addr;
    for (int i = 0; i < 20; i++) begin
      ch   = $urandom_range(0, NB_CH - 1);
      sz   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 700);
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom();
      cfg  = 3'($urandom_range(0, 7));
      set_req(ch, addr, sz, 1'($urandom_range(0, 1)));
      serve(1'b0, 0, 3, 1'b1, g, nb);
    end
  endtask

  task automatic test_reset_mid();
    int g, nb, cyc;
    cfg = 3'd0;
    set_req(1, 32'h0000_0200, 32, 1'b1);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (req_ready[1] !== 1'b1 && cyc < 40);
    @(negedge clk);
    req_valid[1] = 1'b0;
    phy_ready    = 1'b1;
    @(negedge clk);
    phy_ready = 1'b0;
    checks++;
    if (busy !== 2'b10 || phy_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_wait: got busy=%b phy_valid=%b expected 10/0", busy, phy_valid);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({req_ready, phy_valid, phy_addr, phy_len, phy_rwn, phy_id, phy_last, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b addr=%h len=%0d busy=%b expected all 0",
               phy_valid, phy_addr, phy_len, busy);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    m_ptr  = 0;
    set_req(0, 32'h0000_0300, 8, 1'b0);
    set_req(1, 32'h0000_0400, 16, 1'b1);
    serve(1'b0, 0, 2, 1'b1, g, nb);
    checks++;
    if (g !== 0) begin
      errors++;
      $display("FAIL post_reset_first: got channel %0d expected 0", g);
    end
    serve(1'b0, 0, 2, 1'b1, g, nb);
    checks++;
    if (g !== 1) begin
      errors++;
      $display("FAIL post_reset_second: got channel %0d expected 1", g);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_page_split();
    test_size0();
    test_drop();
    test_round_robin();
    test_back_pressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
